// File: rtl/eth_pkg.sv
// Shared types and helpers for the receive-side Ethernet MAC address filter.
// Holds the filter state encoding and the station-address byte-order helper.
package eth_pkg;

    localparam int MAC_W = 48;
    localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SOF  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } filt_state_e;

    // local_mac[47:40] is the first byte on the wire, which lands in tdata[7:0].
    function automatic logic [MAC_W-1:0] mac_wire_order(input logic [MAC_W-1:0] mac);
        logic [MAC_W-1:0] wire_mac;
        wire_mac = '0;
        for (int i = 0; i < MAC_W / 8; i++) begin
            wire_mac[8*i +: 8] = mac[MAC_W-1-8*i -: 8];
        end
        return wire_mac;
    endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module eth_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter on the RX AXI-Stream: classifies each frame on its
// first beat, forwards accepted frames through one register stage, eats the rest.
module eth_rx_mac_filter
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    input  logic [MAC_W-1:0]      local_mac,
    input  logic                  promisc_en,
    input  logic                  bcast_en,
    input  logic                  mcast_en,

    output logic [CNT_WIDTH-1:0]  pass_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  drop_pulse,
    output logic [1:0]            dbg_state
);

    generate
        if (DATA_WIDTH != 64) begin : g_bad_width
            $error("eth_rx_mac_filter supports only DATA_WIDTH = 64");
        end
    endgenerate

    // Handshake: a beat moves on a port in every cycle where valid && ready are
    // both high at the rising edge; valid never waits on ready, and tready here
    // is a function of registered state and m_axis_tready only.

    filt_state_e state_q;
    filt_state_e state_d;

    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_tuser_q, m_tuser_d;
    logic                  drop_pulse_q, drop_pulse_d;

    logic             s_ready;
    logic             s_hs;
    logic             load;
    logic             pass_inc;
    logic             drop_inc;
    logic [MAC_W-1:0] dst;
    logic             is_runt;
    logic             is_bcast;
    logic             is_mcast;
    logic             is_ucast;
    logic             accept;

    // Classification of the beat currently on the input; only used at SOF.
    always_comb begin
        dst      = s_axis_tdata[MAC_W-1:0];
        is_runt  = (s_axis_tkeep[5:0] != 6'h3F);
        is_bcast = (dst == BCAST_MAC);
        is_mcast = dst[0] && !is_bcast;
        is_ucast = (dst == mac_wire_order(local_mac));
        accept   = !is_runt &&
                   (promisc_en || is_ucast ||
                    (is_bcast && bcast_en) ||
                    (is_mcast && mcast_en));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SOF: begin
                if (s_hs && !s_axis_tlast) begin
                    state_d = accept ? PASS : DROP;
                end
            end
            PASS, DROP: begin
                if (s_hs && s_axis_tlast) begin
                    state_d = SOF;
                end
            end
            default: state_d = SOF;
        endcase
    end

    always_comb begin
        s_ready  = (state_q == DROP) ? 1'b1 : (!m_tvalid_q || m_axis_tready);
        s_hs     = s_axis_tvalid && s_ready;
        load     = 1'b0;
        pass_inc = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            SOF: begin
                if (s_hs) begin
                    load     = accept;
                    pass_inc = accept;
                    drop_inc = !accept;
                end
            end
            PASS:    load = s_hs;
            default: load = 1'b0;
        endcase
    end

    // The output slot empties when taken downstream and refills on any load.
    always_comb begin
        m_tvalid_d   = m_tvalid_q && !m_axis_tready;
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tlast_d    = m_tlast_q;
        m_tuser_d    = m_tuser_q;
        drop_pulse_d = drop_inc;
        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis_tdata;
            m_tkeep_d  = s_axis_tkeep;
            m_tlast_d  = s_axis_tlast;
            m_tuser_d  = s_axis_tuser;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    eth_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pass_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (pass_inc),
        .count  (pass_count)
    );

    eth_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (drop_inc),
        .count  (drop_count)
    );

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;
    assign drop_pulse    = drop_pulse_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Self-checking bench for eth_rx_mac_filter: scoreboarded output stream,
// counter/pulse checks, backpressure, runt and mid-frame reset scenarios.
module tb_eth_rx_mac_filter;

    logic        clk;
    logic        resetn;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [47:0] local_mac;
    logic        promisc_en;
    logic        bcast_en;
    logic        mcast_en;
    logic [31:0] pass_count;
    logic [31:0] drop_count;
    logic        drop_pulse;
    logic [1:0]  dbg_state;

    // Second instance with 2-bit counters to reach saturation quickly.
    logic        sat_s_tready;
    logic [63:0] sat_m_tdata;
    logic [7:0]  sat_m_tkeep;
    logic        sat_m_tvalid;
    logic        sat_m_tlast;
    logic        sat_m_tuser;
    logic [1:0]  sat_pass_count;
    logic [1:0]  sat_drop_count;
    logic        sat_drop_pulse;
    logic [1:0]  sat_dbg_state;

    int checks;
    int failures;
    logic [73:0] exp_q[$];
    int exp_pass;
    int exp_drop;
    int pulse_seen;
    bit rand_ready;

    localparam logic [47:0] LOCAL_MAC  = 48'h0200_0000_0001;
    localparam logic [47:0] DST_LOCAL  = 48'h0100_0000_0002;
    localparam logic [47:0] DST_MISS   = 48'h0200_0000_0002;
    localparam logic [47:0] DST_BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DST_MCAST  = 48'h0100_005E_0001;

    eth_rx_mac_filter dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .local_mac     (local_mac),
        .promisc_en    (promisc_en),
        .bcast_en      (bcast_en),
        .mcast_en      (mcast_en),
        .pass_count    (pass_count),
        .drop_count    (drop_count),
        .drop_pulse    (drop_pulse),
        .dbg_state     (dbg_state)
    );

    eth_rx_mac_filter #(.CNT_WIDTH(2)) dut_sat (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (sat_s_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (sat_m_tdata),
        .m_axis_tkeep  (sat_m_tkeep),
        .m_axis_tvalid (sat_m_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (sat_m_tlast),
        .m_axis_tuser  (sat_m_tuser),
        .local_mac     (local_mac),
        .promisc_en    (promisc_en),
        .bcast_en      (bcast_en),
        .mcast_en      (mcast_en),
        .pass_count    (sat_pass_count),
        .drop_count    (sat_drop_count),
        .drop_pulse    (sat_drop_pulse),
        .dbg_state     (sat_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Downstream ready: always 1, or a fair coin per cycle when rand_ready.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic        prev_stall;
        logic [73:0] prev_beat;
        logic [73:0] got;
        logic [73:0] exp;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            got = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
            if (resetn) begin
                if (prev_stall) begin
                    checks++;
                    if (!m_axis_tvalid || got !== prev_beat) begin
                        failures++;
                        $display("FAIL stall_stable: got valid=%0b beat=%h required valid=1 beat=%h",
                                 m_axis_tvalid, got, prev_beat);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL out_beat: got unexpected beat %h required no output", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            failures++;
                            $display("FAIL out_beat: got %h required %h", got, exp);
                        end
                    end
                end
                if (drop_pulse) pulse_seen++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = got;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- reference classification ----------------
    function automatic bit model_accept(input logic [47:0] d, input logic [7:0] k);
        bit ucast;
        bit bcast;
        if (k[5:0] != 6'h3F) return 1'b0;
        if (promisc_en) return 1'b1;
        ucast = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (d[8*i +: 8] != local_mac[47-8*i -: 8]) ucast = 1'b0;
        end
        if (ucast) return 1'b1;
        bcast = (d == 48'hFFFF_FFFF_FFFF);
        if (bcast) return bcast_en;
        if (d[0]) return mcast_en;
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic u, input bit fwd, output int tries);
        bit hs;
        if (fwd) exp_q.push_back({l, u, k, d});
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        tries = 0;
        hs    = 1'b0;
        while (!hs && tries < 200) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            tries++;
        end
        s_axis_tvalid = 1'b0;
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL hs_timeout: got no s_axis_tready in %0d cycles required handshake", tries);
        end
    endtask

    task automatic send_frame(input logic [47:0] d, input int nbeats);
        bit          fwd;
        int          tries;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        fwd = model_accept(d, 8'hFF);
        if (fwd) exp_pass++;
        else     exp_drop++;
        for (int b = 0; b < nbeats; b++) begin
            data = {$urandom(), $urandom()};
            if (b == 0) data[47:0] = d;
            last = (b == nbeats - 1);
            keep = 8'hFF;
            if (last && b != 0) keep = 8'($urandom_range(1, 255));
            user = last ? 1'($urandom_range(0, 1)) : 1'b0;
            send_beat(data, keep, last, user, fwd, tries);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        local_mac     = LOCAL_MAC;
        promisc_en    = 1'b0;
        bcast_en      = 1'b0;
        mcast_en      = 1'b0;
        idle(3);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'h0 || m_axis_tkeep !== 8'h0 ||
            m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got valid=%0b data=%h keep=%h last=%0b user=%0b required all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
        end
        checks++;
        if (pass_count !== 32'd0 || drop_count !== 32'd0 || drop_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_counts: got pass=%0d drop=%0d pulse=%0b required 0 0 0",
                     pass_count, drop_count, drop_pulse);
        end
        checks++;
        if (dbg_state !== 2'd0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got state=%0d tready=%0b required state=0 tready=1",
                     dbg_state, s_axis_tready);
        end
        @(negedge clk);
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_unicast();
        logic [63:0] beats[3];
        logic [7:0]  keeps[3];
        int          tries;
        beats[0] = {16'hA1B2, DST_LOCAL};
        beats[1] = 64'h1122_3344_5566_7788;
        beats[2] = 64'h99AA_BBCC_DDEE_F001;
        keeps[0] = 8'hFF;
        keeps[1] = 8'hFF;
        keeps[2] = 8'h0F;
        exp_pass++;
        for (int b = 0; b < 3; b++) begin
            send_beat(beats[b], keeps[b], (b == 2), 1'b0, 1'b1, tries);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== beats[b] || m_axis_tkeep !== keeps[b]) begin
                failures++;
                $display("FAIL ucast_latency beat%0d: got valid=%0b data=%h keep=%h required valid=1 data=%h keep=%h",
                         b, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, beats[b], keeps[b]);
            end
        end
        idle(2);
        checks++;
        if (pass_count !== 32'(exp_pass) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ucast_count: got pass=%0d pending=%0d required pass=%0d pending=0",
                     pass_count, exp_q.size(), exp_pass);
        end
    endtask

    task automatic test_unicast_miss();
        int tries;
        int pulse_base;
        pulse_base = pulse_seen;
        exp_drop++;
        for (int b = 0; b < 3; b++) begin
            send_beat((b == 0) ? {16'h5A5A, DST_MISS} : 64'(b), 8'hFF, (b == 2), 1'b0, 1'b0, tries);
            checks++;
            if (tries != 1 || m_axis_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL miss_beat%0d: got tries=%0d valid=%0b required tries=1 valid=0",
                         b, tries, m_axis_tvalid);
            end
        end
        idle(2);
        checks++;
        if (drop_count !== 32'(exp_drop) || pulse_seen - pulse_base != 1) begin
            failures++;
            $display("FAIL miss_count: got drop=%0d pulses=%0d required drop=%0d pulses=1",
                     drop_count, pulse_seen - pulse_base, exp_drop);
        end
    endtask

    task automatic test_bcast_mcast();
        bcast_en = 1'b0;
        send_frame(DST_BCAST, 2);
        idle(2);
        checks++;
        if (drop_count !== 32'(exp_drop) || pass_count !== 32'(exp_pass)) begin
            failures++;
            $display("FAIL bcast_off: got pass=%0d drop=%0d required pass=%0d drop=%0d",
                     pass_count, drop_count, exp_pass, exp_drop);
        end
        bcast_en = 1'b1;
        send_frame(DST_BCAST, 2);
        idle(2);
        checks++;
        if (drop_count !== 32'(exp_drop) || pass_count !== 32'(exp_pass)) begin
            failures++;
            $display("FAIL bcast_on: got pass=%0d drop=%0d required pass=%0d drop=%0d",
                     pass_count, drop_count, exp_pass, exp_drop);
        end
        bcast_en = 1'b0;
        mcast_en = 1'b1;
        send_frame(DST_MCAST, 3);
        mcast_en = 1'b0;
        idle(2);
        checks++;
        if (drop_count !== 32'(exp_drop) || pass_count !== 32'(exp_pass) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mcast_on: got pass=%0d drop=%0d pending=%0d required pass=%0d drop=%0d pending=0",
                     pass_count, drop_count, exp_q.size(), exp_pass, exp_drop);
        end
    endtask

    task automatic test_runt_single();
        int tries;
        exp_drop++;
        send_beat({16'h0000, DST_LOCAL}, 8'h1F, 1'b1, 1'b0, 1'b0, tries);
        checks++;
        if (dbg_state !== 2'd0 || m_axis_tvalid !== 1'b0 || drop_count !== 32'(exp_drop)) begin
            failures++;
            $display("FAIL runt: got state=%0d valid=%0b drop=%0d required state=0 valid=0 drop=%0d",
                     dbg_state, m_axis_tvalid, drop_count, exp_drop);
        end
        exp_pass++;
        send_beat({16'hBEEF, DST_LOCAL}, 8'hFF, 1'b1, 1'b1, 1'b1, tries);
        checks++;
        if (dbg_state !== 2'd0 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 ||
            m_axis_tuser !== 1'b1 || pass_count !== 32'(exp_pass)) begin
            failures++;
            $display("FAIL single_beat: got state=%0d valid=%0b last=%0b user=%0b pass=%0d required 0 1 1 1 %0d",
                     dbg_state, m_axis_tvalid, m_axis_tlast, m_axis_tuser, pass_count, exp_pass);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int pass_base;
        int drop_base;
        int pulse_base;
        int waited;
        pass_base  = exp_pass;
        drop_base  = exp_drop;
        pulse_base = pulse_seen;
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            send_frame((f % 2 == 0) ? DST_LOCAL : DST_MISS, $urandom_range(1, 4));
        end
        rand_ready = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            idle(1);
            waited++;
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: got %0d beats outstanding required 0", exp_q.size());
        end
        checks++;
        if (pass_count !== 32'(exp_pass) || drop_count !== 32'(exp_drop) ||
            exp_pass - pass_base != 10 || exp_drop - drop_base != 10 ||
            pulse_seen - pulse_base != 10) begin
            failures++;
            $display("FAIL b2b_counts: got pass=%0d drop=%0d pulses=%0d required pass=%0d drop=%0d pulses=10",
                     pass_count, drop_count, pulse_seen - pulse_base, exp_pass, exp_drop);
        end
        checks++;
        if (sat_pass_count !== 2'((exp_pass > 3) ? 3 : exp_pass) ||
            sat_drop_count !== 2'((exp_drop > 3) ? 3 : exp_drop)) begin
            failures++;
            $display("FAIL saturate: got pass=%0d drop=%0d required pass=%0d drop=%0d",
                     sat_pass_count, sat_drop_count,
                     (exp_pass > 3) ? 3 : exp_pass, (exp_drop > 3) ? 3 : exp_drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        int tries;
        int pulse_base;
        send_beat({16'h1234, DST_LOCAL}, 8'hFF, 1'b0, 1'b0, 1'b1, tries);
        s_axis_tdata  = 64'hDEAD_BEEF_0000_0002;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || pass_count !== 32'd0 || drop_count !== 32'd0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid: got valid=%0b pass=%0d drop=%0d state=%0d required 0 0 0 0",
                     m_axis_tvalid, pass_count, drop_count, dbg_state);
        end
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        exp_pass = 0;
        exp_drop = 0;
        idle(2);
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        pulse_base = pulse_seen;
        send_frame(DST_LOCAL, 3);
        send_frame(DST_MISS, 2);
        idle(3);
        checks++;
        if (pass_count !== 32'd1 || drop_count !== 32'd1 || exp_q.size() != 0 ||
            pulse_seen - pulse_base != 1) begin
            failures++;
            $display("FAIL after_reset: got pass=%0d drop=%0d pending=%0d pulses=%0d required 1 1 0 1",
                     pass_count, drop_count, exp_q.size(), pulse_seen - pulse_base);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_pass   = 0;
        exp_drop   = 0;
        pulse_seen = 0;
        rand_ready = 1'b0;
        test_reset();
        test_unicast();
        test_unicast_miss();
        test_bcast_mcast();
        test_runt_single();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
